// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, x/y counters, registered syncs and blanking.
// Define BOARD_WINDOW_EN to compile in the board locator (in_board, cell_x, cell_y).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned BOARD_X0   = 270,
  parameter int unsigned BOARD_Y0   = 190,
  parameter int unsigned BOARD_SIZE = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blank_b,
  output logic       frame_start,
  output logic       in_board,
  output logic [6:0] cell_x,
  output logic [6:0] cell_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Board geometry must fit the visible area and the 7-bit cell outputs.
  if (BOARD_X0 + BOARD_SIZE > H_ACTIVE || BOARD_Y0 + BOARD_SIZE > V_ACTIVE ||
      BOARD_SIZE > 128) begin : g_bad_board
    $error("vga_timing_gen: board window does not fit");
  end

  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       blank_b_d;
  logic       frame_start_d;

  // Syncs and blanking are decoded from the next counts so that they land on
  // the same edge as x/y.
  always_comb begin
    x_d           = x;
    y_d           = y;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (x == X_LAST) begin
        x_d = '0;
        if (y == Y_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y + 10'd1;
        end
      end else begin
        x_d = x + 10'd1;
      end
    end
    hsync_d   = !((x_d >= HS_START) && (x_d < HS_END));
    vsync_d   = !((y_d >= VS_START) && (y_d < VS_END));
    blank_b_d = (x_d < X_VIS) && (y_d < Y_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_b     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      x           <= x_d;
      y           <= y_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      blank_b     <= blank_b_d;
      frame_start <= frame_start_d;
    end
  end

`ifdef BOARD_WINDOW_EN
  localparam logic [9:0] BX_LO = 10'(BOARD_X0);
  localparam logic [9:0] BX_HI = 10'(BOARD_X0 + BOARD_SIZE);
  localparam logic [9:0] BY_LO = 10'(BOARD_Y0);
  localparam logic [9:0] BY_HI = 10'(BOARD_Y0 + BOARD_SIZE);

  logic in_board_d;

  always_comb begin
    in_board_d = blank_b_d && (x_d >= BX_LO) && (x_d < BX_HI) &&
                 (y_d >= BY_LO) && (y_d < BY_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_board <= 1'b0;
      cell_x   <= '0;
      cell_y   <= '0;
    end else begin
      in_board <= in_board_d;
      cell_x   <= in_board_d ? 7'(x_d - BX_LO) : 7'd0;
      cell_y   <= in_board_d ? 7'(y_d - BY_LO) : 7'd0;
    end
  end
`else
  assign in_board = 1'b0;
  assign cell_x   = 7'd0;
  assign cell_y   = 7'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size instance for reset and line
// timing, a shrunken-geometry instance for whole-frame and board checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       blank_b;
    logic       frame_start;
    logic       in_board;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] cell_x;
    logic [6:0] cell_y;
  } obs_t;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int bx; int by; int bs;
  } geo_t;

  localparam geo_t G_BIG = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2,
                             vb: 33, bx: 270, by: 190, bs: 100};
  localparam geo_t G_SML = '{ha: 16, hf: 2, hs: 4, hb: 3, va: 12, vf: 2, vs: 2,
                             vb: 3, bx: 4, by: 3, bs: 5};
  localparam obs_t RST_OBS = '{pix_en: 1'b0, hsync: 1'b1, vsync: 1'b1, blank_b: 1'b1,
                               frame_start: 1'b0, in_board: 1'b0, x: 10'd0, y: 10'd0,
                               cell_x: 7'd0, cell_y: 7'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       pe_b, hs_b, vs_b, bl_b, fs_b, ib_b;
  logic [9:0] x_b, y_b;
  logic [6:0] cx_b, cy_b;
  logic       pe_s, hs_s, vs_s, bl_s, fs_s, ib_s;
  logic [9:0] x_s, y_s;
  logic [6:0] cx_s, cy_s;
  obs_t       obs_b, obs_s;

  int n_checks = 0;
  int n_pass = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .x(x_b),
    .y(y_b), .blank_b(bl_b), .frame_start(fs_b), .in_board(ib_b), .cell_x(cx_b),
    .cell_y(cy_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2),
    .V_BP(3), .BOARD_X0(4), .BOARD_Y0(3), .BOARD_SIZE(5)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pe_s), .hsync(hs_s), .vsync(vs_s), .x(x_s),
    .y(y_s), .blank_b(bl_s), .frame_start(fs_s), .in_board(ib_s), .cell_x(cx_s),
    .cell_y(cy_s)
  );

  assign obs_b = {pe_b, hs_b, vs_b, bl_b, fs_b, ib_b, x_b, y_b, cx_b, cy_b};
  assign obs_s = {pe_s, hs_s, vs_s, bl_s, fs_s, ib_s, x_s, y_s, cx_s, cy_s};

  // Closed-form expectation for the n-th clk edge after reset release:
  // n/2 pixel strobes have elapsed, so (x,y) follows from that raster index.
  function automatic obs_t model(geo_t g, int n);
    obs_t o;
    int   htot, vtot, p, px, py;
    logic inb;
    htot = g.ha + g.hf + g.hs + g.hb;
    vtot = g.va + g.vf + g.vs + g.vb;
    p    = n / 2;
    px   = p % htot;
    py   = (p / htot) % vtot;
    o.pix_en      = (n % 2) == 1;
    o.x           = 10'(px);
    o.y           = 10'(py);
    o.hsync       = !(px >= g.ha + g.hf && px < g.ha + g.hf + g.hs);
    o.vsync       = !(py >= g.va + g.vf && py < g.va + g.vf + g.vs);
    o.blank_b     = px < g.ha && py < g.va;
    o.frame_start = n > 0 && (n % 2) == 0 && (p % (htot * vtot)) == 0;
`ifdef BOARD_WINDOW_EN
    inb = o.blank_b && px >= g.bx && px < g.bx + g.bs && py >= g.by && py < g.by + g.bs;
`else
    inb = 1'b0;
`endif
    o.in_board = inb;
    o.cell_x   = inb ? 7'(px - g.bx) : 7'd0;
    o.cell_y   = inb ? 7'(py - g.by) : 7'd0;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(int k);
    reset = 1'b1;
    repeat (k) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(RST_OBS);
      tick();
      got = obs_b;
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL reset_hold[%0d]: got %h want %h", i, got, exp);
      else n_pass++;
    end
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      sb.push_back(model(G_BIG, n));
      tick();
      got = obs_b;
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL reset_release[%0d]: got %h want %h", n, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_one_line();
    obs_t exp, got;
    int   hs_cnt = 0, hs_first = -1, bl_first = -1, errs = 0;
    hold_reset(2);
    for (int n = 1; n <= 1604; n++) begin
      sb.push_back(model(G_BIG, n));
      tick();
      got = obs_b;
      exp = sb.pop_front();
      if (got !== exp) begin
        errs++;
        if (errs <= 5) $display("FAIL line_sb[n=%0d]: got %h want %h", n, got, exp);
      end
      if (got.y == 10'd0 && !got.hsync && got.pix_en) hs_cnt++;
      if (got.y == 10'd0 && !got.hsync && hs_first < 0) hs_first = int'(got.x);
      if (got.y == 10'd0 && !got.blank_b && bl_first < 0) bl_first = int'(got.x);
      if (n == 1600) begin
        n_checks++;
        if (got.x !== 10'd0 || got.y !== 10'd1)
          $display("FAIL line_wrap: got x=%0d y=%0d want x=0 y=1", got.x, got.y);
        else n_pass++;
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL line_scoreboard: got %0d errors want 0", errs);
    else n_pass++;
    n_checks++;
    if (hs_cnt != 96) $display("FAIL hsync_width: got %0d want 96", hs_cnt);
    else n_pass++;
    n_checks++;
    if (hs_first != 656) $display("FAIL hsync_start: got %0d want 656", hs_first);
    else n_pass++;
    n_checks++;
    if (bl_first != 640) $display("FAIL blank_fall: got %0d want 640", bl_first);
    else n_pass++;
  endtask

  task automatic test_frames();
    obs_t exp, got;
    int   errs = 0, vs_cnt = 0, fs_cnt = 0, fs_last = -1, fs_gap_bad = 0, fs_pos_bad = 0;
    int   ib_cnt = 0, ib_first = -1, ib_last = -1;
    hold_reset(2);
    for (int n = 1; n <= 1904; n++) begin
      sb.push_back(model(G_SML, n));
      tick();
      got = obs_s;
      exp = sb.pop_front();
      if (got !== exp) begin
        errs++;
        if (errs <= 5) $display("FAIL frame_sb[n=%0d]: got %h want %h", n, got, exp);
      end
      if (!got.vsync && got.pix_en) vs_cnt++;
      if (got.frame_start) begin
        fs_cnt++;
        if (got.x != 10'd0 || got.y != 10'd0) fs_pos_bad++;
        if (fs_last >= 0 && n - fs_last != 950) fs_gap_bad++;
        fs_last = n;
      end
      if (got.in_board && got.pix_en && n < 950) begin
        ib_cnt++;
        if (ib_first < 0) ib_first = int'({got.x, got.y, got.cell_x, got.cell_y});
        ib_last = int'({got.x, got.y, got.cell_x, got.cell_y});
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL frame_scoreboard: got %0d errors want 0", errs);
    else n_pass++;
    n_checks++;
    if (vs_cnt != 100) $display("FAIL vsync_strobes: got %0d want 100", vs_cnt);
    else n_pass++;
    n_checks++;
    if (fs_cnt != 2 || fs_pos_bad != 0 || fs_gap_bad != 0)
      $display("FAIL frame_start: got cnt=%0d pos_bad=%0d gap_bad=%0d want 2/0/0",
               fs_cnt, fs_pos_bad, fs_gap_bad);
    else n_pass++;
`ifdef BOARD_WINDOW_EN
    n_checks++;
    if (ib_cnt != 25) $display("FAIL board_count: got %0d want 25", ib_cnt);
    else n_pass++;
    n_checks++;
    if (ib_first != int'({10'd4, 10'd3, 7'd0, 7'd0}))
      $display("FAIL board_first: got %h want %h", ib_first, {10'd4, 10'd3, 7'd0, 7'd0});
    else n_pass++;
    n_checks++;
    if (ib_last != int'({10'd8, 10'd7, 7'd4, 7'd4}))
      $display("FAIL board_last: got %h want %h", ib_last, {10'd8, 10'd7, 7'd4, 7'd4});
    else n_pass++;
`else
    n_checks++;
    if (ib_cnt != 0 || ib_last != -1) $display("FAIL board_off: got %0d want 0", ib_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_mid_reset();
    obs_t exp, got;
    hold_reset(2);
    repeat (320) tick();
    n_checks++;
    if (x_s !== 10'd10 || y_s !== 10'd6)
      $display("FAIL mid_position: got x=%0d y=%0d want x=10 y=6", x_s, y_s);
    else n_pass++;
    reset = 1'b1;
    sb.push_back(RST_OBS);
    tick();
    reset = 1'b0;
    got = obs_s;
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL mid_reset: got %h want %h", got, exp);
    else n_pass++;
    for (int n = 1; n <= 6; n++) begin
      sb.push_back(model(G_SML, n));
      tick();
      got = obs_s;
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL mid_resume[%0d]: got %h want %h", n, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_one_line();
    test_frames();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
